// File: rtl/score_display_ctrl.sv
// Two-player score keeper that draws each score as a 4-column x 9-row digit glyph.
// Optional macro WIN_FLASH_EN blinks the winner's digit while the game is over.
module score_display_ctrl #(
   parameter logic [3:0] WIN_SCORE    = 4'd7,
   parameter logic [7:0] FLASH_FRAMES = 8'd30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        p1_point,
   input  logic        p2_point,
   input  logic        clear,
   output logic [35:0] p1_glyph,
   output logic [35:0] p2_glyph,
   output logic        p1_visible,
   output logic        p2_visible,
   output logic        busy,
   output logic        game_over,
   output logic        winner
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, OVER} state_t;

   state_t      state_reg, state_next;
   logic [1:0]  col_reg, col_next;
   logic [3:0]  s1_reg, s1_next, s2_reg, s2_next;
   logic        pend1_reg, pend1_next, pend2_reg, pend2_next;
   logic [35:0] p1_glyph_reg, p1_glyph_next, p2_glyph_reg, p2_glyph_next;
   logic        game_over_reg, game_over_next;
   logic        winner_reg, winner_next;
   logic [35:0] font1, font2;
`ifdef WIN_FLASH_EN
   logic [7:0]  flash_reg, flash_next;
   logic        vis1_reg, vis1_next, vis2_reg, vis2_next;
`endif

   // Glyph packing is {col3, col2, col1, col0}; bit 0 of each column is the top row.
   function automatic logic [35:0] font(input logic [3:0] d);
      case (d)
         4'd0:    font = {9'h1FF, 9'h101, 9'h101, 9'h1FF};
         4'd1:    font = {9'h000, 9'h1FF, 9'h000, 9'h000};
         4'd2:    font = {9'h11F, 9'h111, 9'h111, 9'h1F1};
         4'd3:    font = {9'h1FF, 9'h111, 9'h111, 9'h111};
         4'd4:    font = {9'h1FF, 9'h010, 9'h010, 9'h01F};
         4'd5:    font = {9'h1F1, 9'h111, 9'h111, 9'h11F};
         4'd6:    font = {9'h1F1, 9'h111, 9'h111, 9'h1FF};
         4'd7:    font = {9'h1FF, 9'h001, 9'h001, 9'h001};
         4'd8:    font = {9'h1FF, 9'h111, 9'h111, 9'h1FF};
         4'd9:    font = {9'h1FF, 9'h111, 9'h111, 9'h11F};
         default: font = 36'h0;
      endcase
   endfunction

   assign font1 = font(s1_reg);
   assign font2 = font(s2_reg);

   always_comb begin
      state_next     = state_reg;
      col_next       = col_reg;
      s1_next        = s1_reg;
      s2_next        = s2_reg;
      pend1_next     = pend1_reg;
      pend2_next     = pend2_reg;
      p1_glyph_next  = p1_glyph_reg;
      p2_glyph_next  = p2_glyph_reg;
      game_over_next = game_over_reg;
      winner_next    = winner_reg;
`ifdef WIN_FLASH_EN
      flash_next     = flash_reg;
      vis1_next      = vis1_reg;
      vis2_next      = vis2_reg;
`endif

      unique case (state_reg)
         IDLE: begin
            pend1_next = pend1_reg | p1_point;
            pend2_next = pend2_reg | p2_point;
            state_next = LOAD;
            col_next   = 2'd0;
         end
         LOAD: begin
            for (int k = 0; k < 4; k++) begin
               if (col_reg == 2'(k)) begin
                  p1_glyph_next[9*k +: 9] = font1[9*k +: 9];
                  p2_glyph_next[9*k +: 9] = font2[9*k +: 9];
               end
            end
            col_next = col_reg + 2'd1;
            if (col_reg == 2'd3) begin
               if (s1_reg == WIN_SCORE || s2_reg == WIN_SCORE) begin
                  state_next     = OVER;
                  game_over_next = 1'b1;
                  winner_next    = (s1_reg != WIN_SCORE);
               end else begin
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (frame_tick && (pend1_reg || pend2_reg)) begin
               if (pend1_reg && s1_reg < WIN_SCORE) s1_next = s1_reg + 4'd1;
               if (pend2_reg && s2_reg < WIN_SCORE) s2_next = s2_reg + 4'd1;
               // A pulse landing on the applying tick starts the next frame's pend.
               pend1_next = p1_point;
               pend2_next = p2_point;
               state_next = LOAD;
               col_next   = 2'd0;
            end else begin
               pend1_next = pend1_reg | p1_point;
               pend2_next = pend2_reg | p2_point;
            end
         end
         OVER: begin
`ifdef WIN_FLASH_EN
            if (frame_tick) begin
               if (flash_reg == 8'(FLASH_FRAMES - 8'd1)) begin
                  flash_next = 8'd0;
                  if (winner_reg) vis2_next = ~vis2_reg;
                  else            vis1_next = ~vis1_reg;
               end else begin
                  flash_next = flash_reg + 8'd1;
               end
            end
`endif
         end
         default: state_next = IDLE;
      endcase

      // New game: glyphs keep their old columns until LOAD overwrites them.
      if (clear) begin
         s1_next        = 4'd0;
         s2_next        = 4'd0;
         pend1_next     = 1'b0;
         pend2_next     = 1'b0;
         game_over_next = 1'b0;
         winner_next    = 1'b0;
         state_next     = LOAD;
         col_next       = 2'd0;
`ifdef WIN_FLASH_EN
         flash_next     = 8'd0;
         vis1_next      = 1'b1;
         vis2_next      = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= IDLE;
         col_reg       <= 2'd0;
         s1_reg        <= 4'd0;
         s2_reg        <= 4'd0;
         pend1_reg     <= 1'b0;
         pend2_reg     <= 1'b0;
         p1_glyph_reg  <= 36'h0;
         p2_glyph_reg  <= 36'h0;
         game_over_reg <= 1'b0;
         winner_reg    <= 1'b0;
`ifdef WIN_FLASH_EN
         flash_reg     <= 8'd0;
         vis1_reg      <= 1'b1;
         vis2_reg      <= 1'b1;
`endif
      end else begin
         state_reg     <= state_next;
         col_reg       <= col_next;
         s1_reg        <= s1_next;
         s2_reg        <= s2_next;
         pend1_reg     <= pend1_next;
         pend2_reg     <= pend2_next;
         p1_glyph_reg  <= p1_glyph_next;
         p2_glyph_reg  <= p2_glyph_next;
         game_over_reg <= game_over_next;
         winner_reg    <= winner_next;
`ifdef WIN_FLASH_EN
         flash_reg     <= flash_next;
         vis1_reg      <= vis1_next;
         vis2_reg      <= vis2_next;
`endif
      end
   end

   assign p1_glyph  = p1_glyph_reg;
   assign p2_glyph  = p2_glyph_reg;
   assign busy      = (state_reg == LOAD);
   assign game_over = game_over_reg;
   assign winner    = winner_reg;
`ifdef WIN_FLASH_EN
   assign p1_visible = vis1_reg;
   assign p2_visible = vis2_reg;
`else
   assign p1_visible = 1'b1;
   assign p2_visible = 1'b1;
`endif

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 4'd7, meaning the score (1..9) that ends the game.
REQ-002 The block SHALL have parameter FLASH_FRAMES, default 8'd30, meaning the frame_tick count per winner-glyph blink phase.
REQ-003 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  reset; synchronous and active-low (reset==0 resets).
REQ-005 Port: frame_tick  input  1  one-cycle pulse per video frame.
REQ-006 Port: p1_point  input  1  one-cycle pulse, player 1 scored.
REQ-007 Port: p2_point  input  1  one-cycle pulse, player 2 scored.
REQ-008 Port: clear  input  1  one-cycle pulse, start a new game.
REQ-009 Port: p1_glyph  output  36  P1 digit columns: [8:0] to Matrix0, [17:9] to Matrix1, [26:18] to Matrix2, [35:27] to Matrix3; bit 0 of each column is the top row.
REQ-010 Port: p2_glyph  output  36  P2 digit columns, same packing.
REQ-011 Port: p1_visible / p2_visible  output  1 each  display enable for each digit object.
REQ-012 Port: busy  output  1  high while glyph columns are being written.
REQ-013 Port: game_over  output  1  high once a player reaches WIN_SCORE.
REQ-014 Port: winner  output  1  0 = P1, 1 = P2; valid only while game_over is high.

Function
REQ-015 Scores SHALL be 4-bit registers s1 and s2 that saturate at WIN_SCORE.
REQ-016 FSM states SHALL be IDLE, LOAD, RUN and OVER.
REQ-017 A point pulse SHALL set a sticky pend flag for that player.
- A second pulse while the flag is set is dropped (max +1 per frame).
- Point pulses in OVER or LOAD are ignored.
REQ-018 In RUN, frame_tick with any pend flag set SHALL, in the same edge:
- increment each pending score;
- clear both pend flags;
- enter LOAD.
- frame_tick with no pend flag keeps RUN.
REQ-019 A point pulse in the same cycle as frame_tick SHALL set pend only; it is applied at the next frame_tick.
REQ-020 LOAD SHALL last exactly 4 cycles, with busy=1 throughout.
- Cycle k (k=0..3) writes column k of both glyph outputs from the font of s1/s2.
- Columns not yet written hold their previous values.
REQ-021 After LOAD, the FSM SHALL enter OVER if s1==WIN_SCORE or s2==WIN_SCORE, else RUN.
- winner=0 if s1==WIN_SCORE (P1 priority on a simultaneous win), else 1.
- game_over=1 from the first OVER cycle.
REQ-022 IDLE SHALL last one cycle after reset and then enter LOAD, which draws "0" "0".
REQ-023 In any state, clear SHALL, on the next edge:
- zero s1, s2 and the pend flags;
- deassert game_over and winner;
- set both visible outputs to 1;
- restart LOAD at column 0.
REQ-024 The font SHALL cover digits 0..9 as 4 columns x 9 rows.
- Digit 0: 1FF, 101, 101, 1FF.
- Digit 1: 000, 000, 1FF, 000.
- Digit 7: 001, 001, 001, 1FF.
- Columns are listed col0..col3, in hex.
REQ-025 OVER SHALL persist until clear or reset.

Reset
REQ-026 With reset==0 at an edge, outputs SHALL be:
- p1_glyph and p2_glyph = 0 (blank);
- p1_visible and p2_visible = 1;
- busy, game_over and winner = 0.
- Internally: s1, s2, pend flags and flash counter = 0; state = IDLE.
REQ-027 Reset SHALL override clear, frame_tick and point inputs, including mid-LOAD; the first cycle after release is IDLE.

Configuration
REQ-028 Macro WIN_FLASH_EN SHALL control winner blinking.
- Defined: in OVER, an 8-bit counter counts frame_ticks. Every FLASH_FRAMES ticks the winner's visible output toggles and the counter wraps to 0. The loser's visible output stays 1. Both visible outputs return to 1 on clear or reset.
- Undefined: no counter is built, and both visible outputs are constant 1.

Verification
REQ-029 Reset release: after 1 IDLE cycle and 4 busy cycles, both glyphs SHALL equal {1FF, 101, 101, 1FF}, then RUN with busy=0.
REQ-030 p1_point, then frame_tick 10 cycles later: busy SHALL be high for 4 cycles, and p1_glyph SHALL become digit 1 while p2_glyph stays digit 0.
REQ-031 Two p1_point pulses before one frame_tick: s1 SHALL increase by exactly 1; p1_point coincident with frame_tick SHALL be applied only at the following frame_tick.
REQ-032 s1=s2=6 with WIN_SCORE=7, both pending, frame_tick: both glyphs SHALL show digit 7, game_over=1 and winner=0; subsequent point pulses SHALL leave the scores unchanged.
REQ-033 With WIN_FLASH_EN defined and FLASH_FRAMES=2, in OVER: the winner's visible SHALL toggle every 2 frame_ticks while the loser's stays 1; a clear SHALL return both to 1 and redraw "0" "0".
REQ-034 reset asserted during LOAD cycle 2: all outputs SHALL match REQ-026 on the next edge.
